// File: rtl/color_fsm_sequencer.sv
// color_fsm_sequencer
//   Shares a single two-state Blue/Red colour FSM among NUM_REQ requesters.
//   A requester is granted in round-robin order and its target colour is
//   latched. The sequencer then issues at most one TOGGLE command to the
//   colour FSM and watches the FSM output until the target appears. It then
//   pulses a one-hot ack, flagged as an error on timeout or when the FSM
//   output encoding is illegal.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          asynchronous, active-high reset
//   req_valid    per-requester request, held until the matching ack
//   req_color    per-requester target colour (0 = Blue, 1 = Red)
//   req_ack      one-hot, one-cycle completion pulse
//   req_err      qualifies req_ack: timeout or illegal FSM encoding
//   grant_id     index of the requester currently being served
//   busy         high whenever the sequencer is not idle
//   fsm_in       command to the colour FSM (2'h1 = TOGGLE, 2'h3 = NOP)
//   fsm_out      colour FSM output (2'h1 = Blue, 2'h2 = Red, others illegal)
//   toggle_cnt   saturating count of TOGGLE commands issued
//
// All outputs are decoded from registered state only.

module color_fsm_sequencer #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned IDW     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_color,
    output logic [NUM_REQ-1:0] req_ack,
    output logic               req_err,
    output logic [IDW-1:0]     grant_id,
    output logic               busy,
    output logic [1:0]         fsm_in,
    input  logic [1:0]         fsm_out,
    output logic [15:0]        toggle_cnt
);

    localparam int unsigned SELW = $clog2(NUM_REQ);
    localparam int unsigned TW   = $clog2(TIMEOUT);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;

    localparam logic [1:0] CMD_TOGGLE = 2'h1;
    localparam logic [1:0] CMD_NOP    = 2'h3;
    localparam logic [1:0] COL_BLUE   = 2'h1;
    localparam logic [1:0] COL_RED    = 2'h2;

    logic [2:0]      state_q,      state_d;
    logic [SELW-1:0] grant_q,      grant_d;
    logic            target_q,     target_d;
    logic            err_q,        err_d;
    logic [SELW-1:0] rr_q,         rr_d;
    logic [TW-1:0]   timer_q,      timer_d;
    logic [15:0]     toggle_cnt_q, toggle_cnt_d;

    logic            pick_found;
    logic [SELW-1:0] pick_idx;
    logic [31:0]     cand;
    logic            fsm_legal;
    logic            fsm_match;

    // Round-robin pick: first pending requester at or after rr_q, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_found && req_valid[SELW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = SELW'(cand);
            end
        end
    end

    // The latched target is always a legal encoding, so an illegal fsm_out
    // never matches and simply runs into the timeout while waiting.
    always_comb begin
        fsm_legal = (fsm_out == COL_BLUE) || (fsm_out == COL_RED);
        fsm_match = target_q ? (fsm_out == COL_RED) : (fsm_out == COL_BLUE);
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        target_d     = target_q;
        err_d        = err_q;
        rr_d         = rr_q;
        timer_d      = timer_q;
        toggle_cnt_d = toggle_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d  = pick_idx;
                    target_d = req_color[pick_idx];
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!fsm_legal) begin
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                end else if (fsm_match) begin
                    err_d   = 1'b0;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (toggle_cnt_q != 16'hFFFF) begin
                    toggle_cnt_d = toggle_cnt_q + 16'd1;
                end
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fsm_match) begin
                    err_d   = 1'b0;
                    state_d = ST_ACK;
                end else if (32'(timer_q) == TIMEOUT - 1) begin
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_ACK: begin
                if (32'(grant_q) == NUM_REQ - 1) begin
                    rr_d = '0;
                end else begin
                    rr_d = grant_q + SELW'(1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            target_q     <= 1'b0;
            err_q        <= 1'b0;
            rr_q         <= '0;
            timer_q      <= '0;
            toggle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            target_q     <= target_d;
            err_q        <= err_d;
            rr_q         <= rr_d;
            timer_q      <= timer_d;
            toggle_cnt_q <= toggle_cnt_d;
        end
    end

    always_comb begin
        req_ack = '0;
        if (state_q == ST_ACK) begin
            req_ack[grant_q] = 1'b1;
        end
    end

    assign req_err    = (state_q == ST_ACK) && err_q;
    assign grant_id   = IDW'(grant_q);
    assign busy       = (state_q != ST_IDLE);
    assign fsm_in     = (state_q == ST_ISSUE) ? CMD_TOGGLE : CMD_NOP;
    assign toggle_cnt = toggle_cnt_q;

endmodule
